// File: rtl/bubble_page_loader_pkg.sv
// bubble_page_loader_pkg: shared FSM states, page geometry and default loader parameters.
package bubble_page_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CALC,
        REQ,
        WAIT,
        WR_SETUP,
        WR_HIGH,
        WR_LOW,
        NEXT,
        FIN
    } state_t;

    localparam int          PAGE_BYTES      = 480;
    localparam int          DEF_PAGE_WORDS  = 1920;
    localparam logic [23:0] DEF_BOOT_OFFSET = 24'h000000;
    localparam logic [23:0] DEF_PAGE_BASE   = 24'h001000;
    localparam int          DEF_MAX_PAGES   = 2053;

    // n*480 built as (n<<9)-(n<<5) so no multiplier is needed
    function automatic logic [23:0] page_offset(input logic [11:0] n);
        return ({12'd0, n} << 9) - ({12'd0, n} << 5);
    endfunction

endpackage

// File: rtl/bubble_page_loader_if.sv
// bubble_page_loader_if: load requests, flash byte reads and bubble-buffer write port.
interface bubble_page_loader_if;

    logic [2:0]  image_dip_switch;
    logic        load_page;
    logic        load_bootloader;
    logic [11:0] page_number;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [10:0] bubble_buffer_write_address;
    logic [1:0]  bubble_buffer_write_data_input;
    logic        bubble_buffer_write_enable;
    logic        bubble_buffer_write_clock;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  image_dip_switch, load_page, load_bootloader, page_number, rd_data, rd_valid,
        output rd_req, rd_addr, bubble_buffer_write_address, bubble_buffer_write_data_input,
               bubble_buffer_write_enable, bubble_buffer_write_clock, busy, done, error
    );

    modport slave (
        output image_dip_switch, load_page, load_bootloader, page_number, rd_data, rd_valid,
        input  rd_req, rd_addr, bubble_buffer_write_address, bubble_buffer_write_data_input,
               bubble_buffer_write_enable, bubble_buffer_write_clock, busy, done, error
    );

endinterface

// File: rtl/bubble_page_loader.sv
// bubble_page_loader: fetches a page image from flash byte by byte and strobes it into the
// bubble buffer as 2-bit words, MSB pair first.
module bubble_page_loader
    import bubble_page_loader_pkg::*;
#(
    parameter int          PAGE_WORDS  = DEF_PAGE_WORDS,
    parameter logic [23:0] BOOT_OFFSET = DEF_BOOT_OFFSET,
    parameter logic [23:0] PAGE_BASE   = DEF_PAGE_BASE,
    parameter int          MAX_PAGES   = DEF_MAX_PAGES
) (
    input  logic                 master_clock,
    input  logic                 reset,
    bubble_page_loader_if.master bus
);

    localparam logic [10:0] LAST_WORD  = 11'(PAGE_WORDS - 1);
    localparam logic [11:0] PAGE_LIMIT = 12'(MAX_PAGES);

    state_t      state_q;
    logic        boot_q;
    logic [2:0]  dip_q;
    logic [11:0] page_q;
    logic [23:0] base_q;
    logic [8:0]  byte_q;
    logic [10:0] word_q;
    logic [7:0]  data_q;
    logic        rd_req_q;
    logic [23:0] rd_addr_q;
    logic [10:0] wa_q;
    logic [1:0]  wd_q;
    logic        we_q;
    logic        wc_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [23:0] base_d;
    logic [8:0]  byte_d;
    logic [10:0] word_d;
    logic        bad_page;

    always_comb begin
        base_d   = {dip_q, 21'd0} + (boot_q ? BOOT_OFFSET : PAGE_BASE + page_offset(page_q));
        byte_d   = byte_q + 9'd1;
        word_d   = word_q + 11'd1;
        bad_page = !boot_q && page_q >= PAGE_LIMIT;
    end

    // outputs are registered on the transition into the state that owns them
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_q   <= IDLE;
            boot_q    <= 1'b0;
            dip_q     <= '0;
            page_q    <= '0;
            base_q    <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            data_q    <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            we_q      <= 1'b1;
            wc_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.load_bootloader || bus.load_page) begin
                    boot_q  <= bus.load_bootloader;
                    dip_q   <= bus.image_dip_switch;
                    page_q  <= bus.page_number;
                    byte_q  <= '0;
                    word_q  <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= CALC;
                end
                CALC: if (bad_page) begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= FIN;
                end else begin
                    base_q    <= base_d;
                    rd_req_q  <= 1'b1;
                    rd_addr_q <= base_d;
                    state_q   <= REQ;
                end
                REQ: state_q <= WAIT;
                WAIT: if (bus.rd_valid) begin
                    rd_req_q <= 1'b0;
                    data_q   <= {bus.rd_data[5:0], 2'b00};
                    wa_q     <= word_q;
                    wd_q     <= bus.rd_data[7:6];
                    we_q     <= 1'b0;
                    state_q  <= WR_SETUP;
                end
                WR_SETUP: begin
                    wc_q    <= 1'b1;
                    state_q <= WR_HIGH;
                end
                WR_HIGH: begin
                    wc_q    <= 1'b0;
                    state_q <= WR_LOW;
                end
                WR_LOW: state_q <= NEXT;
                NEXT: begin
                    word_q <= word_d;
                    if (word_q == LAST_WORD) begin
                        we_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else if (word_q[1:0] == 2'd3) begin
                        byte_q    <= byte_d;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= base_q + {15'd0, byte_d};
                        state_q   <= REQ;
                    end else begin
                        wa_q    <= word_d;
                        wd_q    <= data_q[7:6];
                        data_q  <= {data_q[5:0], 2'b00};
                        state_q <= WR_SETUP;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_req                         = rd_req_q;
    assign bus.rd_addr                        = rd_addr_q;
    assign bus.bubble_buffer_write_address    = wa_q;
    assign bus.bubble_buffer_write_data_input = wd_q;
    assign bus.bubble_buffer_write_enable     = we_q;
    assign bus.bubble_buffer_write_clock      = wc_q;
    assign bus.busy                           = busy_q;
    assign bus.done                           = done_q;
    assign bus.error                          = err_q;

endmodule
